// File: rtl/rmt_arb_pkg.sv
// ---------------------------------------------------------------------------
// rmt_arb_pkg
//   Shared definitions for the RMT ingress packet arbiter:
//   - arb_state_t : arbiter FSM encoding (IDLE = 0, BUSY = 1)
//   - CNT_W       : width of each per-port packet counter (stats build)
//   - port_id_w() : width of a port index (clog2 of the port count, min 1)
//   - slice_lo()  : low bit of port N's field in a flattened per-port bus
// ---------------------------------------------------------------------------
package rmt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned CNT_W = 32;

  function automatic int unsigned port_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rmt_pkt_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Returns the first requesting port
//   strictly after ptr, wrapping modulo NUM_PORTS. If only the port at ptr
//   is requesting, it is picked (it is the last one searched).
// Ports
//   req     in   NUM_PORTS  request vector
//   ptr     in   ID_W       last-served port
//   pick    out  ID_W       selected port (0 when nothing requests)
//   any_req out  1          at least one request present
// ---------------------------------------------------------------------------
module rr_picker
  import rmt_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_W      = port_id_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [ID_W-1:0]      pick,
  output logic                 any_req
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    pick    = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rmt_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// rmt_pkt_arbiter
//   Packet-granular round-robin arbiter sharing the RMT pipeline AXI-Stream
//   ingress between NUM_PORTS sources. A grant is held from the first beat
//   through tlast so packets never interleave. One output register stage
//   drives rmt_wrapper s_axis_*.
//
//   Optional feature macro: RMT_PKT_ARB_STATS_EN
//     defined   -> adds pkt_cnt (NUM_PORTS*32), per-port packets forwarded,
//                  +1 on every accepted tlast beat, wrapping, reset to 0.
//     undefined -> no pkt_cnt port, no counters; arbitration identical.
//
// Ports
//   clk            in   1                 AXIS clock
//   areset         in   1                 async active-high reset
//   s_axis_tdata   in   NUM_PORTS*DW      port i at [i*DW +: DW]
//   s_axis_tkeep   in   NUM_PORTS*DW/8    per-port byte enables
//   s_axis_tuser   in   NUM_PORTS*UW      per-port tuser
//   s_axis_tvalid  in   NUM_PORTS         per-port valid
//   s_axis_tlast   in   NUM_PORTS         per-port end of packet
//   s_axis_tready  out  NUM_PORTS         only the granted bit can be 1
//   m_axis_*       out  DW/DW/8/UW/1/1    registered output beat
//   m_axis_tready  in   1                 downstream backpressure
//   grant_id       out  clog2(NUM_PORTS)  current / last granted port
//   pkt_cnt        out  NUM_PORTS*32      (stats build only)
// ---------------------------------------------------------------------------
module rmt_pkt_arbiter
  import rmt_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                         clk,
  input  logic                                         areset,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                         s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                         s_axis_tlast,
  output logic [NUM_PORTS-1:0]                         s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  output logic [port_id_w(NUM_PORTS)-1:0]              grant_id
`ifdef RMT_PKT_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0]                   pkt_cnt
`endif
);

  localparam int unsigned DW   = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KW   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW   = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned ID_W = port_id_w(NUM_PORTS);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick;
  logic            any_req;

  logic [DW-1:0]   sel_tdata;
  logic [KW-1:0]   sel_tkeep;
  logic [UW-1:0]   sel_tuser;
  logic            sel_tlast;
  logic            sel_tvalid;
  logic            grant_ready;
  logic            accept;
  logic            accept_last;

  // -------------------------------------------------------------------------
  // Round-robin pick among requesting ports, starting after rr_ptr
  // -------------------------------------------------------------------------
  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_rr_picker (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  // -------------------------------------------------------------------------
  // Granted-port beat mux
  // -------------------------------------------------------------------------
  always_comb begin
    sel_tdata = '0;
    sel_tkeep = '0;
    sel_tuser = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_tdata = s_axis_tdata[slice_lo(i, DW) +: DW];
        sel_tkeep = s_axis_tkeep[slice_lo(i, KW) +: KW];
        sel_tuser = s_axis_tuser[slice_lo(i, UW) +: UW];
      end
    end
  end

  assign sel_tlast   = s_axis_tlast[grant_id];
  assign sel_tvalid  = s_axis_tvalid[grant_id];
  assign accept      = grant_ready & sel_tvalid;
  assign accept_last = accept & sel_tlast;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = BUSY;
      BUSY:    if (accept_last) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Nothing is accepted in IDLE, which costs one bubble per
  // packet but keeps the pick off the ready path.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_ready   = (state == BUSY) & (~m_axis_tvalid | m_axis_tready);
    s_axis_tready = '0;
    s_axis_tready[grant_id] = grant_ready;
  end

  // -------------------------------------------------------------------------
  // Grant and round-robin pointer. The pointer moves only at packet end, so
  // a source that stalls mid-packet keeps its turn.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_PORTS - 1);
    end else begin
      if (state == IDLE && any_req) begin
        grant_id <= pick;
      end
      if (accept_last) begin
        rr_ptr <= grant_id;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_tdata;
      m_axis_tkeep  <= sel_tkeep;
      m_axis_tuser  <= sel_tuser;
      m_axis_tlast  <= sel_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef RMT_PKT_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Per-port forwarded-packet counters (wrap naturally at 2^32)
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] pkt_cnt_q [NUM_PORTS];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else if (accept_last) begin
      pkt_cnt_q[grant_id] <= pkt_cnt_q[grant_id] + CNT_W'(1);
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pkt_cnt[slice_lo(i, CNT_W) +: CNT_W] = pkt_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_rmt_pkt_arbiter.sv
module tb_rmt_pkt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 16;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              areset;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N*UW-1:0]   s_tuser;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [IW-1:0]     grant_id;
`ifdef RMT_PKT_ARB_STATS_EN
  logic [N*32-1:0]   pkt_cnt;
`endif

  always #5 clk = ~clk;

  rmt_pkt_arbiter #(
    .NUM_PORTS            (N),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_id      (grant_id)
`ifdef RMT_PKT_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            t;
  } beat_t;

  beat_t out_q[$];
  beat_t pq[N][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int p, input int pk, input int b, input int r);
    return {8'(p), 8'(pk), 8'(b), 8'h5A, 32'(r)};
  endfunction

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic l);
    beat_t x;
    x.data = d;
    x.keep = d[7:0] | 8'h01;
    x.user = d[23:8] ^ 16'hA5C3;
    x.last = l;
    x.t    = 0;
    return x;
  endfunction

  task automatic drive(input logic [IW-1:0] p, input logic v, input logic [DW-1:0] d, input logic l);
    beat_t x;
    x = mk_beat(d, l);
    s_tvalid[p]          = v;
    s_tlast[p]           = l;
    s_tdata[p*DW +: DW]  = x.data;
    s_tkeep[p*KW +: KW]  = x.keep;
    s_tuser[p*UW +: UW]  = x.user;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic cmp_stream(input string nm, input beat_t e[$]);
    chk({nm, "_count"}, 64'(out_q.size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < out_q.size(); k++) begin
      chk({nm, "_data"}, out_q[k].data, e[k].data);
      chk({nm, "_keep"}, 64'(out_q[k].keep), 64'(e[k].keep));
      chk({nm, "_user"}, 64'(out_q[k].user), 64'(e[k].user));
      chk({nm, "_last"}, 64'(out_q[k].last), 64'(e[k].last));
    end
  endtask

  task automatic send_pkt(input logic [IW-1:0] p, input int len, input int tag);
    int   b     = 0;
    int   guard = 0;
    logic acc;
    while (b < len && guard < 100) begin
      drive(p, 1'b1, mk_data(int'(p), tag, b, tag * 131 + b), (b == len - 1));
      #1;
      acc = s_tvalid[p] & s_tready[p];
      tick();
      guard++;
      if (acc) b++;
    end
    s_tvalid[p] = 1'b0;
    chk("send_done", 64'(b), 64'(len));
  endtask

  // Output monitor: records handshakes and checks AXIS hold while stalled
  always @(posedge clk) cyc_cnt++;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    beat_t x;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", m_tdata, prev_data);
      end
      if (m_tvalid && m_tready) begin
        x.data = m_tdata;
        x.keep = m_tkeep;
        x.user = m_tuser;
        x.last = m_tlast;
        x.t    = cyc_cnt;
        out_q.push_back(x);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  // Reference model: grants go to the requester at the smallest forward
  // distance from the last-served port; a whole packet drains before any
  // other grant; outputs appear one cycle after acceptance.
  task automatic run_traffic(input bit rnd_valid, input bit rnd_ready, output beat_t exp[$]);
    int            ptr_m  = N - 1;
    bit            busy_m = 0;
    int            g_m    = 0;
    bit            outv_m = 0;
    bit            asrt[N];
    int            cyc    = 0;
    bit            pend;
    logic [N-1:0]  exp_rdy;
    bit            acc;
    bit            nxt_v;
    int            best;
    int            bestd;
    int            d;
    beat_t         b;
    exp.delete();
    for (int p = 0; p < N; p++) asrt[p] = 0;
    pend = 1;
    while ((pend || busy_m || outv_m) && cyc < 4000) begin
      for (int p = 0; p < N; p++) begin
        if (!asrt[p] && pq[p].size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) asrt[p] = 1;
        if (asrt[p]) drive(IW'(p), 1'b1, pq[p][0].data, pq[p][0].last);
        else         s_tvalid[IW'(p)] = 1'b0;
      end
      m_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      exp_rdy = '0;
      if (busy_m && (!outv_m || m_tready)) exp_rdy[IW'(g_m)] = 1'b1;
      chk("mdl_ready", 64'(s_tready), 64'(exp_rdy));
      chk("mdl_valid", 64'(m_tvalid), 64'(outv_m));
      chk("mdl_grant", 64'(grant_id), 64'(g_m));
      acc   = busy_m && asrt[g_m] && exp_rdy[IW'(g_m)];
      nxt_v = acc ? 1'b1 : (m_tready ? 1'b0 : outv_m);
      if (!busy_m) begin
        best  = -1;
        bestd = N;
        for (int q = 0; q < N; q++) begin
          d = (q - ptr_m - 1 + 2 * N) % N;
          if (asrt[q] && d < bestd) begin
            bestd = d;
            best  = q;
          end
        end
        if (best >= 0) begin
          busy_m = 1;
          g_m    = best;
        end
      end else if (acc) begin
        b = pq[g_m].pop_front();
        exp.push_back(b);
        asrt[g_m] = 0;
        if (b.last) begin
          busy_m = 0;
          ptr_m  = g_m;
        end
      end
      outv_m = nxt_v;
      tick();
      cyc++;
      pend = 0;
      for (int p = 0; p < N; p++) if (pq[p].size() > 0) pend = 1;
    end
    chk("traffic_drained", 64'(pend || busy_m || outv_m), 64'd0);
    s_tvalid = '0;
    m_tready = 1'b1;
    tick();
    tick();
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [IW-1:0] gnt;
  } vec_t;

  initial begin
    vec_t          tbl[12];
    logic [DW-1:0] vdata[N];
    beat_t         exp[$];
    beat_t         e3[$];
    beat_t         e4[$];
    logic [DW-1:0] d;
    logic          acc;
    int            b;
    int            cyc;

    tbl[0]  = '{req: 4'b0110, gnt: 2'd1};
    tbl[1]  = '{req: 4'b1111, gnt: 2'd2};
    tbl[2]  = '{req: 4'b0011, gnt: 2'd0};
    tbl[3]  = '{req: 4'b1000, gnt: 2'd3};
    tbl[4]  = '{req: 4'b0101, gnt: 2'd0};
    tbl[5]  = '{req: 4'b0010, gnt: 2'd1};
    tbl[6]  = '{req: 4'b0001, gnt: 2'd0};
    tbl[7]  = '{req: 4'b0001, gnt: 2'd0};
    tbl[8]  = '{req: 4'b1001, gnt: 2'd3};
    tbl[9]  = '{req: 4'b1111, gnt: 2'd0};
    tbl[10] = '{req: 4'b1110, gnt: 2'd1};
    tbl[11] = '{req: 4'b1100, gnt: 2'd2};

    // ---- 1: reset values, first grant and latency --------------------------
    areset   = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    d = mk_data(2, 1, 0, 32'h1234);
    drive(2'd2, 1'b1, d, 1'b1);
    areset = 1'b0;
    tick();
    chk("t1_grant", 64'(grant_id), 64'd2);
    chk("t1_valid_c1", 64'(m_tvalid), 64'd0);
    tick();
    s_tvalid = '0;
    chk("t1_valid_c2", 64'(m_tvalid), 64'd1);
    chk("t1_data", m_tdata, d);
    chk("t1_last", 64'(m_tlast), 64'd1);
    tick();

    // ---- table: round-robin picks from reset pointer -----------------------
    do_reset();
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < N; i++) begin
        vdata[i] = mk_data(i, 40 + v, 0, v * 17 + i);
        if (tbl[v].req[IW'(i)]) drive(IW'(i), 1'b1, vdata[i], 1'b1);
      end
      tick();
      chk("tbl_grant", 64'(grant_id), 64'(tbl[v].gnt));
      chk("tbl_ready", 64'(s_tready), 64'(4'b0001 << tbl[v].gnt));
      tick();
      s_tvalid = '0;
      chk("tbl_out_valid", 64'(m_tvalid), 64'd1);
      chk("tbl_out_data", m_tdata, vdata[tbl[v].gnt]);
      tick();
    end

    // ---- 2: all ports continuous 3-beat packets, strict rotation -----------
    do_reset();
    out_q.delete();
    e3.delete();
    for (int pk = 0; pk < 2; pk++)
      for (int p = 0; p < N; p++)
        for (int bb = 0; bb < 3; bb++) begin
          pq[p].push_back(mk_beat(mk_data(p, pk, bb, p * 7 + bb), (bb == 2)));
          e3.push_back(mk_beat(mk_data(p, pk, bb, p * 7 + bb), (bb == 2)));
        end
    // e3 was built port-major within each round, which is the rotation order
    run_traffic(1'b0, 1'b0, exp);
    cmp_stream("rot", e3);
    for (int k = 0; k + 1 < out_q.size(); k++)
      chk("rot_gap", 64'(out_q[k + 1].t - out_q[k].t), out_q[k].last ? 64'd2 : 64'd1);

    // ---- 3: granted port drops tvalid mid-packet ---------------------------
    send_pkt(2'd0, 1, 90);
    tick();
    out_q.delete();
    e3.delete();
    for (int bb = 0; bb < 3; bb++) e3.push_back(mk_beat(mk_data(1, 3, bb, bb), (bb == 2)));
    e3.push_back(mk_beat(mk_data(0, 3, 0, 77), 1'b1));
    drive(2'd0, 1'b1, e3[3].data, 1'b1);
    drive(2'd1, 1'b1, e3[0].data, 1'b0);
    tick();
    chk("t3_grant1", 64'(grant_id), 64'd1);
    tick();
    s_tvalid[1] = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("t3_hold_grant", 64'(grant_id), 64'd1);
      chk("t3_ready", 64'(s_tready), 64'b0010);
    end
    drive(2'd1, 1'b1, e3[1].data, 1'b0);
    tick();
    drive(2'd1, 1'b1, e3[2].data, 1'b1);
    tick();
    s_tvalid[1] = 1'b0;
    tick();
    chk("t3_grant0", 64'(grant_id), 64'd0);
    tick();
    s_tvalid[0] = 1'b0;
    repeat (3) tick();
    cmp_stream("t3", e3);

    // ---- 4: toggling m_tready during a 5-beat packet -----------------------
    out_q.delete();
    e4.delete();
    for (int bb = 0; bb < 5; bb++) e4.push_back(mk_beat(mk_data(2, 4, bb, 500 + bb), (bb == 4)));
    b   = 0;
    cyc = 0;
    drive(2'd2, 1'b1, e4[0].data, 1'b0);
    while (b < 5 && cyc < 60) begin
      m_tready = (cyc % 2 == 0);
      #1;
      chk("t4_one_ready", 64'($countones(s_tready) <= 1), 64'd1);
      acc = s_tvalid[2] & s_tready[2];
      tick();
      cyc++;
      if (acc) begin
        b++;
        if (b < 5) drive(2'd2, 1'b1, e4[b].data, (b == 4));
        else       s_tvalid[2] = 1'b0;
      end
    end
    chk("t4_all_accepted", 64'(b), 64'd5);
    m_tready = 1'b1;
    repeat (3) tick();
    cmp_stream("t4", e4);

    // ---- 5: reset mid-packet -----------------------------------------------
    drive(2'd3, 1'b1, mk_data(3, 5, 0, 1), 1'b0);
    tick();
    chk("t5_grant3", 64'(grant_id), 64'd3);
    tick();
    drive(2'd3, 1'b1, mk_data(3, 5, 1, 2), 1'b0);
    tick();
    drive(2'd3, 1'b1, mk_data(3, 5, 2, 3), 1'b0);
    drive(2'd0, 1'b1, mk_data(0, 5, 0, 4), 1'b1);
    areset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t5_rst_ready", 64'(s_tready), 64'd0);
    tick();
    tick();
    areset = 1'b0;
    tick();
    chk("t5_first_port0", 64'(grant_id), 64'd0);
    tick();
    s_tvalid = '0;
    chk("t5_out_valid", 64'(m_tvalid), 64'd1);
    chk("t5_out_data", m_tdata, mk_data(0, 5, 0, 4));
    repeat (2) tick();

    // ---- randomized traffic against the model ------------------------------
    do_reset();
    out_q.delete();
    for (int p = 0; p < N; p++)
      for (int pk = 0; pk < 6; pk++) begin
        b = $urandom_range(1, 4);
        for (int bb = 0; bb < b; bb++)
          pq[p].push_back(mk_beat(mk_data(p, 100 + pk, bb, int'($urandom)), (bb == b - 1)));
      end
    run_traffic(1'b1, 1'b1, exp);
    cmp_stream("rand", exp);

`ifdef RMT_PKT_ARB_STATS_EN
    // ---- stats: 10 packets on port 3 ---------------------------------------
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send_pkt(2'd3, 2, 200 + k);
      tick();
    end
    repeat (2) tick();
    for (int p = 0; p < N; p++)
      chk("stats_cnt", 64'(pkt_cnt[p*32 +: 32]), (p == 3) ? 64'd10 : 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
